mux7_rr_arbiter: RTL and testbench



---
 rtl/mux7_rr_arbiter_pkg.sv | 33 +++
 rtl/mux_7x1.sv | 13 +
 rtl/mux7_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux7_rr_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux7_rr_arbiter_pkg.sv
// Shared constants, state encoding and round-robin search helper for mux7_rr_arbiter.
package mux7_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 7;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request at or above ptr, wrapping 6->0. Scanned far-to-near so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t      p;
    logic [3:0] s;
    p = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      s = 4'(ptr) + 4'(k);
      if (s >= 4'(N_REQ)) s = s - 4'(N_REQ);
      if (req[3'(s)]) begin
        p.found = 1'b1;
        p.idx   = 3'(s);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_7x1.sv
// 7-input 1-bit multiplexer; out-of-range selects return 0.
module mux_7x1 (
  input  logic [6:0] i,
  input  logic [2:0] s,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    if (s < 3'd7) y = i[s];
  end

endmodule

// File: rtl/mux7_rr_arbiter.sv
// Round-robin arbiter sharing a 7:1 bit mux among 7 requesters, with a bounded hold per grant.
module mux7_rr_arbiter
  import mux7_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] ptr_rel;
  pick_t            pick_idle;
  pick_t            pick_rel;
  logic             mux_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // On release the owner moves to the back of the queue: search restarts just past it.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ptr_rel   = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
    pick_idle = rr_pick(req, ptr_q);
    pick_rel  = rr_pick(req, ptr_rel);

    case (state_q)
      ST_IDLE: begin
        if (pick_idle.found) begin
          state_d = ST_GRANT;
          gnt_d   = N_REQ'(1) << pick_idle.idx;
          sel_d   = pick_idle.idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (req[sel_q] && (cnt_q < CNT_W'(MAX_HOLD))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = ptr_rel;
          if (pick_rel.found) begin
            gnt_d = N_REQ'(1) << pick_rel.idx;
            sel_d = pick_rel.idx;
            cnt_d = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  mux_7x1 u_mux (
    .i (din),
    .s (sel_q),
    .y (mux_y)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign y    = mux_y & busy_q;

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// Directed bench for mux7_rr_arbiter at MAX_HOLD = 4, 2 and 1 against a queued reference model.
module tb_mux7_rr_arbiter;

  typedef struct packed {
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] req;
  logic [6:0] din;
  logic [6:0] gnt_o  [3];
  logic [2:0] sel_o  [3];
  logic       busy_o [3];
  logic       y_o    [3];

  int   total;
  int   bad;
  exp_t sb_q[$];

  int hold    [3];
  bit m_busy  [3];
  int m_owner [3];
  int m_sel   [3];
  int m_ptr   [3];
  int m_cnt   [3];
  int fair_cnt[3][7];

  mux7_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .busy(busy_o[0]), .y(y_o[0]));
  mux7_rr_arbiter #(.MAX_HOLD(2), .CNT_W(4)) dut_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .busy(busy_o[1]), .y(y_o[1]));
  mux7_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[2]), .sel(sel_o[2]), .busy(busy_o[2]), .y(y_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_winner(input logic [6:0] r, input int p);
    for (int k = 0; k < 7; k++) begin
      if (r[(p + k) % 7]) return (p + k) % 7;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_busy[n] = 1'b0; m_owner[n] = 0; m_sel[n] = 0; m_ptr[n] = 0; m_cnt[n] = 0;
    end
  endtask

  task automatic model_grant(input int n, input int w);
    m_busy[n] = 1'b1; m_owner[n] = w; m_sel[n] = w; m_cnt[n] = 1;
  endtask

  // Advance one instance by one clock edge given the requests sampled at that edge.
  task automatic model_edge(input int n, input logic [6:0] r);
    int w;
    if (!m_busy[n]) begin
      w = find_winner(r, m_ptr[n]);
      if (w >= 0) model_grant(n, w);
    end else if (r[m_owner[n]] && (m_cnt[n] < hold[n])) begin
      m_cnt[n]++;
    end else begin
      m_ptr[n] = (m_owner[n] + 1) % 7;
      w = find_winner(r, m_ptr[n]);
      if (w >= 0) model_grant(n, w);
      else begin
        m_busy[n] = 1'b0;
        m_cnt[n]  = 0;
      end
    end
  endtask

  task automatic push_expected(input logic [6:0] d);
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      e.busy = m_busy[n];
      e.sel  = 3'(m_sel[n]);
      e.gnt  = m_busy[n] ? (7'd1 << m_owner[n]) : 7'd0;
      e.y    = m_busy[n] ? d[m_owner[n]] : 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h t=%0t", tag, n, obs, exp, $time);
    end
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s inst=%0d observed=empty_queue expected=entry", tag, n);
      end else begin
        e = sb_q.pop_front();
        check({tag, ".gnt"},  n, 32'(gnt_o[n]),  32'(e.gnt));
        check({tag, ".sel"},  n, 32'(sel_o[n]),  32'(e.sel));
        check({tag, ".busy"}, n, 32'(busy_o[n]), 32'(e.busy));
        check({tag, ".y"},    n, 32'(y_o[n]),    32'(e.y));
        if (busy_o[n]) fair_cnt[n][sel_o[n]]++;
      end
    end
  endtask

  task automatic step(input string tag, input logic [6:0] r, input logic [6:0] d);
    @(negedge clk);
    req = r;
    din = d;
    for (int n = 0; n < 3; n++) model_edge(n, r);
    push_expected(d);
    @(posedge clk);
    #1;
    pop_and_check(tag);
  endtask

  initial begin
    int diff;
    total = 0;
    bad   = 0;
    hold  = '{4, 2, 1};
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_expected(din);
    pop_and_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of an active grant.
    step("grant_before_rst", 7'b0000100, 7'b0000100);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_expected(din);
    pop_and_check("async_rst");
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    step("idle_after_rst", 7'b0, 7'b0000100);
    step("idle_after_rst", 7'b0, 7'b0000100);

    for (int k = 0; k < 12; k++) step("single_req", 7'b0001000, 7'b0001000);

    for (int k = 0; k < 20; k++) step("contention", 7'h7F, 7'($urandom));

    step("own6", 7'b1000000, 7'b1000000);
    step("wrap", 7'b0000011, 7'b0000001);
    step("wrap_hold", 7'b0000011, 7'b0000010);

    step("drop_owner2", 7'b0000100, 7'b0000100);
    step("drop_owner2", 7'b0000100, 7'b0000100);
    step("to_idle", 7'b0, 7'b1111111);
    step("regrant2", 7'b0000100, 7'b0000100);

    for (int n = 0; n < 3; n++)
      for (int j = 0; j < 7; j++) fair_cnt[n][j] = 0;
    for (int k = 0; k < 100; k++) step("fair", 7'b1000001, 7'($urandom));
    diff = fair_cnt[2][0] - fair_cnt[2][6];
    if (diff < 0) diff = -diff;
    check("fair_diff_le1", 2, 32'(diff > 1), 32'(0));
    check("fair_total", 2, 32'(fair_cnt[2][0] + fair_cnt[2][6]), 32'(100));

    for (int k = 0; k < 40; k++) step("random", 7'($urandom), 7'($urandom));

    check("queue_drained", 0, 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
